multicycle_ctrl: RTL and testbench

- Main control FSM of the multicycle RV32I subset core (lw, sw, R-type, I-type ALU, beq, jal).
- Sits directly upstream of alu_decoder and drives its aluop[1:0] input; op[5] is routed separately to alu_decoder.opb5.
- Sequences fetch, decode, execute, memory and writeback across multiple cycles.
- Stalls on a single-ready memory handshake.

---
 rtl/multicycle_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM of the multicycle RV32I-subset core (lw, sw, R-type,
//   I-type ALU, beq, jal). It sequences fetch / decode / execute / memory /
//   writeback over several cycles and stalls on a single-signal memory
//   handshake (mem_ready). aluop feeds alu_decoder; op[5] reaches
//   alu_decoder.opb5 on a separate path.
//
//   Optional build macro: ILLEGAL_TRAP_EN
//     defined   : unknown opcodes in DECODE enter a dead-end TRAP state and
//                 raise the sticky 'illegal' output (port exists).
//     undefined : unknown opcodes retire as a nop from DECODE (no port).
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   op[6:0]     in   opcode from the instruction register
//   zero        in   ALU zero flag (used in BEQ)
//   mem_ready   in   current memory access completes this cycle
//   pcwrite     out  PC enable = (branch & zero) | pcupdate
//   adrsrc      out  memory address select (0 = PC, 1 = ALU result reg)
//   memwrite    out  data memory write strobe
//   irwrite     out  instruction register / oldPC enable
//   resultsrc   out  result mux select
//   alusrca     out  ALU A select (00 PC, 01 oldPC, 10 rs1)
//   alusrcb     out  ALU B select (00 rs2, 01 immext, 10 const 4)
//   aluop       out  to alu_decoder (00 add, 01 sub, 10 funct-decoded)
//   immsrc      out  immediate format (00 I, 01 S, 10 B, 11 J)
//   regwrite    out  register file write enable
//   illegal     out  sticky illegal-opcode flag (ILLEGAL_TRAP_EN only)
//   instr_done  out  one-cycle pulse in the last cycle of an instruction
//
//   STATE_W must be at least 4 so that every state has an encoding.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] immsrc,
  output logic       regwrite,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output logic       instr_done
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Decoded (pre-reset-gating) control values
  logic       pcupdate;
  logic       branch;
  logic       adrsrc_dec;
  logic       memwrite_dec;
  logic       irwrite_dec;
  logic [1:0] resultsrc_dec;
  logic [1:0] alusrca_dec;
  logic [1:0] alusrcb_dec;
  logic [1:0] aluop_dec;
  logic [1:0] immsrc_dec;
  logic       regwrite_dec;
  logic       instr_done_dec;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and Moore outputs (mem_ready/zero gating where noted)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    pcupdate       = 1'b0;
    branch         = 1'b0;
    adrsrc_dec     = 1'b0;
    memwrite_dec   = 1'b0;
    irwrite_dec    = 1'b0;
    resultsrc_dec  = 2'b00;
    alusrca_dec    = 2'b00;
    alusrcb_dec    = 2'b00;
    aluop_dec      = 2'b00;
    regwrite_dec   = 1'b0;
    instr_done_dec = 1'b0;

    case (state_reg)
      S_FETCH: begin
        // PC+4 is computed while the instruction is read; both the IR load
        // and the PC update wait for the memory to answer.
        adrsrc_dec    = 1'b0;
        alusrca_dec   = 2'b00;
        alusrcb_dec   = 2'b10;
        aluop_dec     = 2'b00;
        resultsrc_dec = 2'b10;
        irwrite_dec   = mem_ready;
        pcupdate      = mem_ready;
        if (mem_ready) begin
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // oldPC + immext precomputes the branch target for BEQ.
        alusrca_dec = 2'b01;
        alusrcb_dec = 2'b01;
        aluop_dec   = 2'b00;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYP:      state_next = S_EXECUTER;
          OP_ITYP:      state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_next = S_TRAP;
`else
            // Unknown opcode retires here as a nop.
            instr_done_dec = 1'b1;
            state_next     = S_FETCH;
`endif
          end
        endcase
      end

      S_MEMADR: begin
        alusrca_dec = 2'b10;
        alusrcb_dec = 2'b01;
        aluop_dec   = 2'b00;
        state_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        adrsrc_dec    = 1'b1;
        resultsrc_dec = 2'b00;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        resultsrc_dec  = 2'b01;
        regwrite_dec   = 1'b1;
        instr_done_dec = 1'b1;
        state_next     = S_FETCH;
      end

      S_MEMWRITE: begin
        // The strobe stays up until the memory accepts the write; the store
        // retires in that same cycle.
        adrsrc_dec     = 1'b1;
        resultsrc_dec  = 2'b00;
        memwrite_dec   = 1'b1;
        instr_done_dec = mem_ready;
        if (mem_ready) begin
          state_next = S_FETCH;
        end
      end

      S_EXECUTER: begin
        alusrca_dec = 2'b10;
        alusrcb_dec = 2'b00;
        aluop_dec   = 2'b10;
        state_next  = S_ALUWB;
      end

      S_EXECUTEI: begin
        alusrca_dec = 2'b10;
        alusrcb_dec = 2'b01;
        aluop_dec   = 2'b10;
        state_next  = S_ALUWB;
      end

      S_ALUWB: begin
        resultsrc_dec  = 2'b00;
        regwrite_dec   = 1'b1;
        instr_done_dec = 1'b1;
        state_next     = S_FETCH;
      end

      S_BEQ: begin
        // ALU compares rs1 - rs2; the target precomputed in DECODE sits in
        // the ALU result register and is selected by resultsrc=00.
        alusrca_dec    = 2'b10;
        alusrcb_dec    = 2'b00;
        aluop_dec      = 2'b01;
        resultsrc_dec  = 2'b00;
        branch         = 1'b1;
        instr_done_dec = 1'b1;
        state_next     = S_FETCH;
      end

      S_JAL: begin
        // PC <- target from DECODE while oldPC + 4 is formed for rd.
        alusrca_dec   = 2'b01;
        alusrcb_dec   = 2'b10;
        aluop_dec     = 2'b00;
        resultsrc_dec = 2'b00;
        pcupdate      = 1'b1;
        state_next    = S_ALUWB;
      end

`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        // Dead end: only reset leaves this state.
        state_next = S_TRAP;
      end
`endif

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Immediate format follows the opcode directly, independent of state
  // ---------------------------------------------------------------------------
  always_comb begin
    case (op)
      OP_SW:   immsrc_dec = 2'b01;
      OP_BEQ:  immsrc_dec = 2'b10;
      OP_JAL:  immsrc_dec = 2'b11;
      default: immsrc_dec = 2'b00;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  // ---------------------------------------------------------------------------
  // Sticky illegal flag: set on the edge that enters TRAP
  // ---------------------------------------------------------------------------
  logic illegal_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_reg <= 1'b0;
    end else if (state_next == S_TRAP) begin
      illegal_reg <= 1'b1;
    end
  end

  assign illegal = rst_n & illegal_reg;
`endif

  // ---------------------------------------------------------------------------
  // While reset is asserted every output is held at 0 combinationally so no
  // enable can leak out between rst_n falling and the state settling.
  // ---------------------------------------------------------------------------
  assign pcwrite    = rst_n & ((branch & zero) | pcupdate);
  assign adrsrc     = rst_n & adrsrc_dec;
  assign memwrite   = rst_n & memwrite_dec;
  assign irwrite    = rst_n & irwrite_dec;
  assign regwrite   = rst_n & regwrite_dec;
  assign instr_done = rst_n & instr_done_dec;
  assign resultsrc  = rst_n ? resultsrc_dec : 2'b00;
  assign alusrca    = rst_n ? alusrca_dec   : 2'b00;
  assign alusrcb    = rst_n ? alusrcb_dec   : 2'b00;
  assign aluop      = rst_n ? aluop_dec     : 2'b00;
  assign immsrc     = rst_n ? immsrc_dec    : 2'b00;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl. The reference model describes
//   each instruction class as a list of phases; memory phases repeat while
//   mem_ready is low. Per-phase expected outputs come from the control table.
//   Build with +define+ILLEGAL_TRAP_EN to exercise the trap variant.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, instr_done;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop, immsrc;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .immsrc     (immsrc),
    .regwrite   (regwrite),
`ifdef ILLEGAL_TRAP_EN
    .illegal    (illegal),
`endif
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Phases of the reference model
  localparam int P_F    = 0;   // fetch
  localparam int P_D    = 1;   // decode
  localparam int P_MA   = 2;   // memory address
  localparam int P_MR   = 3;   // memory read
  localparam int P_MWB  = 4;   // load writeback
  localparam int P_MW   = 5;   // memory write
  localparam int P_ER   = 6;   // execute register
  localparam int P_EI   = 7;   // execute immediate
  localparam int P_AWB  = 8;   // ALU writeback
  localparam int P_BEQ  = 9;
  localparam int P_JAL  = 10;
  localparam int P_TRAP = 11;
  localparam int P_RST  = 12;  // reset asserted

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] immsrc;
    logic       regwrite;
    logic       instr_done;
    logic       illegal;
  } outs_t;

  int phases[$];

  function automatic bit is_known(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_RTYP) ||
           (o == OP_ITYP) || (o == OP_BEQ) || (o == OP_JAL);
  endfunction

  function automatic void build_phases(input logic [6:0] o);
    phases.delete();
    phases.push_back(P_F);
    phases.push_back(P_D);
    if (o == OP_LW) begin
      phases.push_back(P_MA); phases.push_back(P_MR); phases.push_back(P_MWB);
    end else if (o == OP_SW) begin
      phases.push_back(P_MA); phases.push_back(P_MW);
    end else if (o == OP_RTYP) begin
      phases.push_back(P_ER); phases.push_back(P_AWB);
    end else if (o == OP_ITYP) begin
      phases.push_back(P_EI); phases.push_back(P_AWB);
    end else if (o == OP_BEQ) begin
      phases.push_back(P_BEQ);
    end else if (o == OP_JAL) begin
      phases.push_back(P_JAL); phases.push_back(P_AWB);
    end else begin
`ifdef ILLEGAL_TRAP_EN
      phases.push_back(P_TRAP);
`endif
    end
  endfunction

  function automatic outs_t exp_out(input int ph, input logic [6:0] o,
                                    input logic mr, input logic z);
    outs_t e;
    e = '0;
    if (ph == P_RST) return e;
    e.immsrc = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 :
               (o == OP_JAL) ? 2'b11 : 2'b00;
    case (ph)
      P_F:   begin e.alusrcb = 2'b10; e.resultsrc = 2'b10; e.irwrite = mr; e.pcwrite = mr; end
      P_D: begin
        e.alusrca = 2'b01; e.alusrcb = 2'b01;
`ifndef ILLEGAL_TRAP_EN
        e.instr_done = !is_known(o);
`endif
      end
      P_MA:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
      P_MR:  begin e.adrsrc = 1'b1; end
      P_MWB: begin e.resultsrc = 2'b01; e.regwrite = 1'b1; e.instr_done = 1'b1; end
      P_MW:  begin e.adrsrc = 1'b1; e.memwrite = 1'b1; e.instr_done = mr; end
      P_ER:  begin e.alusrca = 2'b10; e.aluop = 2'b10; end
      P_EI:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; e.aluop = 2'b10; end
      P_AWB: begin e.regwrite = 1'b1; e.instr_done = 1'b1; end
      P_BEQ: begin e.alusrca = 2'b10; e.aluop = 2'b01; e.pcwrite = z; e.instr_done = 1'b1; end
      P_JAL: begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1'b1; end
      P_TRAP: begin e.illegal = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic outs_t dut_outs();
    outs_t d;
    d.pcwrite    = pcwrite;
    d.adrsrc     = adrsrc;
    d.memwrite   = memwrite;
    d.irwrite    = irwrite;
    d.resultsrc  = resultsrc;
    d.alusrca    = alusrca;
    d.alusrcb    = alusrcb;
    d.aluop      = aluop;
    d.immsrc     = immsrc;
    d.regwrite   = regwrite;
    d.instr_done = instr_done;
`ifdef ILLEGAL_TRAP_EN
    d.illegal    = illegal;
`else
    d.illegal    = 1'b0;
`endif
    return d;
  endfunction

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Compare current DUT outputs against the model for phase ph.
  task automatic check_now(input int ph, output outs_t got);
    outs_t e;
    got = dut_outs();
    e   = exp_out(ph, op, mem_ready, zero);
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL outs ph=%0d op=%b mr=%b z=%b got=%h want=%h t=%0t",
               ph, op, mem_ready, zero, got, e, $time);
    end
  endtask

  // One cycle: inputs set just after posedge, outputs checked at negedge.
  task automatic step(input int ph, input logic mr, input logic z, output outs_t got);
    mem_ready = mr;
    zero      = z;
    @(negedge clk);
    check_now(ph, got);
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction through the model, checking every cycle.
  task automatic run_instr(input logic [6:0] o, input int fstall, input int dstall,
                           input bit rnd, input logic zfix,
                           output int done_at, output int mw_cnt,
                           output logic pcw_done, output logic [1:0] imm_done);
    int    idx = 0;
    int    cyc = 0;
    int    fs  = fstall;
    int    ds  = dstall;
    logic  mr, z;
    outs_t g;
    bit    waiting;
    build_phases(o);
    op = o;
    done_at = 0; mw_cnt = 0; pcw_done = 1'b0; imm_done = 2'b00;
    while (idx < phases.size()) begin
      if (rnd) begin
        mr = ($urandom_range(0, 3) != 0);
        z  = 1'($urandom_range(0, 1));
      end else begin
        z = zfix;
        if (phases[idx] == P_F) begin
          mr = (fs == 0); if (fs > 0) fs--;
        end else if (phases[idx] == P_MR || phases[idx] == P_MW) begin
          mr = (ds == 0); if (ds > 0) ds--;
        end else begin
          mr = 1'($urandom_range(0, 1));  // ignored outside memory phases
        end
      end
      step(phases[idx], mr, z, g);
      cyc++;
      if (g.memwrite) mw_cnt++;
      if (g.instr_done && done_at == 0) begin
        done_at = cyc; pcw_done = g.pcwrite; imm_done = g.immsrc;
      end
      waiting = (phases[idx] == P_F || phases[idx] == P_MR || phases[idx] == P_MW) && !mr;
      if (!waiting) idx++;
      if (cyc > 200) begin
        total++; bad++;
        $display("FAIL timeout op=%b cycles=%0d", o, cyc);
        break;
      end
    end
  endtask

  typedef struct {
    logic [6:0] op;
    logic       z;
    int         fst;
    int         dst;
    int         cyc;
    logic [1:0] imm;
    int         mw;
    logic       pcw;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t      g;
    int         done_at, mw_cnt;
    logic       pcw_done;
    logic [1:0] imm_done;
    logic [6:0] rop;
    logic [6:0] legal_ops [6];

    legal_ops = '{OP_LW, OP_SW, OP_RTYP, OP_ITYP, OP_BEQ, OP_JAL};

    //           op       z     fst dst cyc imm    mw pcw
    vecs.push_back('{OP_RTYP, 1'b0, 0, 0, 4, 2'b00, 0, 1'b0});
    vecs.push_back('{OP_ITYP, 1'b1, 0, 0, 4, 2'b00, 0, 1'b0});
    vecs.push_back('{OP_LW,   1'b0, 0, 0, 5, 2'b00, 0, 1'b0});
    vecs.push_back('{OP_LW,   1'b0, 0, 2, 7, 2'b00, 0, 1'b0});
    vecs.push_back('{OP_SW,   1'b0, 0, 0, 4, 2'b01, 1, 1'b0});
    vecs.push_back('{OP_SW,   1'b0, 0, 1, 5, 2'b01, 2, 1'b0});
    vecs.push_back('{OP_BEQ,  1'b1, 0, 0, 3, 2'b10, 0, 1'b1});
    vecs.push_back('{OP_BEQ,  1'b0, 0, 0, 3, 2'b10, 0, 1'b0});
    vecs.push_back('{OP_JAL,  1'b0, 0, 0, 4, 2'b11, 0, 1'b0});
    vecs.push_back('{OP_RTYP, 1'b0, 2, 0, 6, 2'b00, 0, 1'b0});
    vecs.push_back('{OP_LW,   1'b0, 1, 1, 7, 2'b00, 0, 1'b0});
`ifndef ILLEGAL_TRAP_EN
    vecs.push_back('{7'b1111111, 1'b0, 0, 0, 2, 2'b00, 0, 1'b0});
    vecs.push_back('{7'b0000000, 1'b1, 0, 0, 2, 2'b00, 0, 1'b0});
`endif

    // Reset hold: outputs all 0 even with sw opcode and ready/zero high.
    rst_n = 1'b0; op = OP_SW; mem_ready = 1'b1; zero = 1'b1;
    #2;
    check_now(P_RST, g);
    @(negedge clk);
    check_now(P_RST, g);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table vectors (first one also covers the first FETCH after release).
    for (int i = 0; i < vecs.size(); i++) begin
      run_instr(vecs[i].op, vecs[i].fst, vecs[i].dst, 1'b0, vecs[i].z,
                done_at, mw_cnt, pcw_done, imm_done);
      check_int($sformatf("vec%0d_latency", i), done_at, vecs[i].cyc);
      check_int($sformatf("vec%0d_immsrc", i), int'(imm_done), int'(vecs[i].imm));
      check_int($sformatf("vec%0d_memwrite_cycles", i), mw_cnt, vecs[i].mw);
      check_int($sformatf("vec%0d_pcwrite_at_done", i), int'(pcw_done), int'(vecs[i].pcw));
      $display("vec %0d op=%b done_at=%0d mw=%0d", i, vecs[i].op, done_at, mw_cnt);
    end

    // Reset in the middle of a stalled store: memwrite must drop at once.
    op = OP_SW;
    step(P_F, 1'b1, 1'b0, g);
    step(P_D, 1'b1, 1'b0, g);
    step(P_MA, 1'b1, 1'b0, g);
    step(P_MW, 1'b0, 1'b0, g);
    mem_ready = 1'b0;
    #1;
    check_now(P_MW, g);
    rst_n = 1'b0;
    #1;
    check_now(P_RST, g);
    @(posedge clk);
    #1;
    check_now(P_RST, g);
    rst_n = 1'b1;
    run_instr(OP_RTYP, 0, 0, 1'b0, 1'b0, done_at, mw_cnt, pcw_done, imm_done);
    check_int("after_midreset_latency", done_at, 4);
    $display("midreset recovery done_at=%0d", done_at);

`ifdef ILLEGAL_TRAP_EN
    // Illegal opcode: stuck in trap, illegal sticky, no retire pulse.
    run_instr(7'b1111111, 0, 0, 1'b0, 1'b0, done_at, mw_cnt, pcw_done, imm_done);
    check_int("trap_no_done", done_at, 0);
    for (int i = 0; i < 6; i++) begin
      step(P_TRAP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g);
    end
    check_int("trap_illegal_held", int'(illegal), 1);
    rst_n = 1'b0;
    #1;
    check_now(P_RST, g);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(OP_RTYP, 0, 0, 1'b0, 1'b0, done_at, mw_cnt, pcw_done, imm_done);
    check_int("after_trap_latency", done_at, 4);
    $display("trap sequence recovered done_at=%0d", done_at);
`endif

    // Randomized instructions and handshake, checked cycle by cycle.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        rop = 7'($urandom_range(0, 127));
`ifdef ILLEGAL_TRAP_EN
        if (!is_known(rop)) rop = legal_ops[$urandom_range(0, 5)];
`endif
      end else begin
        rop = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(rop, 0, 0, 1'b1, 1'b0, done_at, mw_cnt, pcw_done, imm_done);
      $display("rand %0d op=%b done_at=%0d", n, rop, done_at);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
